// File: rtl/winner_draw_pkg.sv
// winner_draw_pkg
//   Shared types and constants for the animated winner-screen drawer.
//   - state_e : animation FSM states (IDLE, REVEAL, BLINK, HOLD)
//   - color_t : 24-bit RGB colour
//   - PALETTE : per-player colours indexed by player code 0..7
//     (entry 0 is the draw colour; codes above NUM_PLAYERS are remapped to
//     the draw colour by the drawer)
package winner_draw_pkg;

  typedef logic [23:0] color_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    BLINK  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam color_t DRAW_DEFAULT   = 24'h7F7F7F;
  localparam color_t HILITE_DEFAULT = 24'hFFFFFF;
  localparam color_t BG_DEFAULT     = 24'hFFFFFF;
  localparam color_t BORDER_COLOR   = 24'h000000;

  localparam color_t PALETTE [0:7] = '{
    24'h7F7F7F,  // 0: draw
    24'hED1B24,  // 1: red
    24'hFFC90D,  // 2: yellow
    24'h22B14C,  // 3: green
    24'h3F48CC,  // 4: blue
    24'hA349A4,  // 5: purple
    24'h00A2E8,  // 6: cyan
    24'hFF7F27   // 7: orange
  };

endpackage

// File: rtl/winner_anim_ctrl.sv
// winner_anim_ctrl
//   Animation sequencer for the winner screen: reveal wipe, blink, hold.
//   All visual progress advances only on frame_start; show=0 aborts to IDLE.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   frame_start     one-cycle pulse at start of vertical blank
//   show            level, winner screen selected
//   player          winner code, latched on IDLE -> REVEAL
//   state_o         current animation state
//   reveal_rows_o   box rows uncovered so far (saturates at box height)
//   phase_o         blink phase (1 = highlight colour)
//   player_o        latched winner code
module winner_anim_ctrl
  import winner_draw_pkg::*;
#(
  parameter int unsigned BOX_H         = 620,
  parameter int unsigned REVEAL_STEP   = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       show,
  input  logic [2:0] player,
  output state_e     state_o,
  output logic [9:0] reveal_rows_o,
  output logic       phase_o,
  output logic [2:0] player_o
);

  localparam logic [10:0] H11     = 11'(BOX_H);
  localparam logic [10:0] STEP11  = 11'(REVEAL_STEP);
  localparam logic [7:0]  BF_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0]  BT_LAST = 8'(BLINK_TOGGLES - 1);

  state_e      state_q, state_d;
  logic [9:0]  rows_q, rows_d;
  logic [7:0]  blink_q, blink_d;
  logic [7:0]  toggle_q, toggle_d;
  logic        phase_q, phase_d;
  logic [2:0]  player_q, player_d;
  logic [10:0] sum;

  // One extra bit so the saturating add cannot wrap before the compare.
  assign sum = {1'b0, rows_q} + STEP11;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    blink_d  = blink_q;
    toggle_d = toggle_q;
    phase_d  = phase_q;
    player_d = player_q;
    case (state_q)
      IDLE: begin
        if (show) begin
          state_d  = REVEAL;
          player_d = player;
          rows_d   = '0;
          blink_d  = '0;
          toggle_d = '0;
          phase_d  = 1'b0;
        end
      end
      REVEAL: begin
        if (frame_start) begin
          if ({1'b0, rows_q} == H11) state_d = BLINK;
          else if (sum >= H11)       rows_d  = H11[9:0];
          else                       rows_d  = sum[9:0];
        end
      end
      BLINK: begin
        if (frame_start) begin
          if (blink_q == BF_LAST) begin
            blink_d  = '0;
            phase_d  = ~phase_q;
            toggle_d = toggle_q + 8'd1;
            if (toggle_q == BT_LAST) begin
              state_d = HOLD;
              phase_d = 1'b0;
            end
          end else begin
            blink_d = blink_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    // Abort outranks any frame_start handled above.
    if (state_q != IDLE && !show) begin
      state_d  = IDLE;
      rows_d   = '0;
      blink_d  = '0;
      toggle_d = '0;
      phase_d  = 1'b0;
      player_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      blink_q  <= '0;
      toggle_q <= '0;
      phase_q  <= 1'b0;
      player_q <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      blink_q  <= blink_d;
      toggle_q <= toggle_d;
      phase_q  <= phase_d;
      player_q <= player_d;
    end
  end

  assign state_o       = state_q;
  assign reveal_rows_o = rows_q;
  assign phase_o       = phase_q;
  assign player_o      = player_q;

endmodule

// File: rtl/screen_drawer_winner_anim.sv
// screen_drawer_winner_anim
//   Paints the animated winner box (reveal wipe, blink, hold) in the winning
//   player's colour. Output colour is registered: one clock of latency from
//   x/y to rgb_color.
//   Optional macro BORDER_FRAME_EN: adds parameter BORDER_W and a black frame
//   of that width inside the box edges, drawn once revealed.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   x, y         current pixel column/row
//   frame_start  one-cycle pulse at start of vertical blank
//   show         high while the winner screen is selected
//   player       winner code (0 = draw, 1..NUM_PLAYERS = player)
//   rgb_color    registered pixel colour
//   anim_done    high while the animation is in HOLD
module screen_drawer_winner_anim
  import winner_draw_pkg::*;
#(
  parameter int unsigned BOX_X0        = 184,
  parameter int unsigned BOX_X1        = 674,
  parameter int unsigned BOX_Y0        = 55,
  parameter int unsigned BOX_Y1        = 675,
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned REVEAL_STEP   = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 6,
  parameter color_t      BG_COLOR      = BG_DEFAULT,
  parameter color_t      HILITE_COLOR  = HILITE_DEFAULT,
  parameter color_t      DRAW_COLOR    = DRAW_DEFAULT
`ifdef BORDER_FRAME_EN
  ,
  parameter int unsigned BORDER_W      = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_start,
  input  logic        show,
  input  logic [2:0]  player,
  output logic [23:0] rgb_color,
  output logic        anim_done
);

  localparam logic [10:0] X0  = 11'(BOX_X0);
  localparam logic [10:0] X1  = 11'(BOX_X1);
  localparam logic [10:0] Y0  = 11'(BOX_Y0);
  localparam logic [10:0] Y1  = 11'(BOX_Y1);
  localparam logic [2:0]  NP3 = 3'(NUM_PLAYERS);

  state_e      state;
  logic [9:0]  reveal_rows;
  logic        phase;
  logic [2:0]  player_q;
  logic [10:0] xe, ye, rev_lim;
  logic        in_box, revealed, edge_px;
  color_t      pcolor;
  color_t      rgb_q, rgb_d;

  winner_anim_ctrl #(
    .BOX_H        (BOX_Y1 - BOX_Y0),
    .REVEAL_STEP  (REVEAL_STEP),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_TOGGLES(BLINK_TOGGLES)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .show         (show),
    .player       (player),
    .state_o      (state),
    .reveal_rows_o(reveal_rows),
    .phase_o      (phase),
    .player_o     (player_q)
  );

  assign xe       = {1'b0, x};
  assign ye       = {1'b0, y};
  assign rev_lim  = Y0 + {1'b0, reveal_rows};
  assign in_box   = (xe >= X0) && (xe < X1) && (ye >= Y0) && (ye < Y1);
  assign revealed = ye < rev_lim;

`ifdef BORDER_FRAME_EN
  localparam logic [10:0] BW = 11'(BORDER_W);
  assign edge_px = (xe < X0 + BW) || (xe >= X1 - BW) ||
                   (ye < Y0 + BW) || (ye >= Y1 - BW);
`else
  assign edge_px = 1'b0;
`endif

  always_comb begin
    pcolor = PALETTE[player_q];
    if (player_q == 3'd0 || player_q > NP3) pcolor = DRAW_COLOR;
  end

  always_comb begin
    rgb_d = BG_COLOR;
    case (state)
      REVEAL: if (in_box && revealed) rgb_d = edge_px ? BORDER_COLOR : pcolor;
      BLINK:  if (in_box) rgb_d = edge_px ? BORDER_COLOR : (phase ? HILITE_COLOR : pcolor);
      HOLD:   if (in_box) rgb_d = edge_px ? BORDER_COLOR : pcolor;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= BG_COLOR;
    else     rgb_q <= rgb_d;
  end

  assign rgb_color = rgb_q;
  assign anim_done = (state == HOLD);

endmodule

// File: tb/tb_screen_drawer_winner_anim.sv
module tb_screen_drawer_winner_anim;

  localparam logic [23:0] P1   = 24'hED1B24;
  localparam logic [23:0] P2   = 24'hFFC90D;
  localparam logic [23:0] DRAW = 24'h7F7F7F;
  localparam logic [23:0] BG   = 24'hFFFFFF;
  localparam logic [23:0] HI   = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        frame_start = 1'b0;
  logic        show = 1'b0;
  logic [2:0]  player = '0;
  logic [23:0] rgb_color;
  logic        anim_done;

  always #5 clk = ~clk;

  screen_drawer_winner_anim dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .show       (show),
    .player     (player),
    .rgb_color  (rgb_color),
    .anim_done  (anim_done)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        done;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        req = 1'b0;
  logic        pend_q = 1'b0;

  function automatic void cmp(string nm, logic [23:0] a_rgb, logic a_done,
                              logic [23:0] e_rgb, logic e_done);
    n_vec++;
    if (a_rgb !== e_rgb || a_done !== e_done) begin
      n_bad++;
      $display("FAIL %s: got rgb=%06h done=%0b, want rgb=%06h done=%0b",
               nm, a_rgb, a_done, e_rgb, e_done);
    end
  endfunction

  // Expected steady-box pixel: BG outside, black frame when enabled, fill inside.
  function automatic logic [23:0] mdl(int px, int py, logic [23:0] fill);
    if (px < 184 || px >= 674 || py < 55 || py >= 675) return BG;
`ifdef BORDER_FRAME_EN
    if (px < 188 || px >= 670 || py < 59 || py >= 671) return 24'h000000;
`endif
    return fill;
  endfunction

  // Monitor: a probe issued before a posedge is due at the following negedge.
  always @(posedge clk) pend_q <= req;

  always @(negedge clk) begin
    exp_t e;
    if (pend_q) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: output sampled with no expectation queued");
      end else begin
        e = sb.pop_front();
        cmp(e.name, rgb_color, anim_done, e.rgb, e.done);
      end
    end
  end

  task automatic probe(int px, int py, logic [23:0] e, logic d, string nm);
    exp_t ent;
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    req = 1'b1;
    ent.rgb = e;
    ent.done = d;
    ent.name = nm;
    sb.push_back(ent);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic frames(int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #22;
    cmp("reset_state", rgb_color, anim_done, BG, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle(2);
    probe(300, 300, BG, 1'b0, "idle_show0");
    idle(1);

    // Reveal with player 1: 3 frames -> 24 rows.
    show = 1'b1; player = 3'd1;
    idle(1);
    frames(3);
    probe(300, 78, P1, 1'b0, "reveal24_last_row");
    probe(300, 79, BG, 1'b0, "reveal24_first_hidden");
    probe(300, 54, BG, 1'b0, "reveal_above_box");
    player = 3'd2;
    idle(2);
    probe(300, 60, P1, 1'b0, "reveal_player_change_ignored");
    idle(1);

    // Asynchronous reset mid-reveal.
    #2 rst = 1'b1;
    #1 cmp("reset_mid_reveal", rgb_color, anim_done, BG, 1'b0);
    @(negedge clk) show = 1'b0;
    @(negedge clk) rst = 1'b0;
    idle(3);
    probe(300, 60, BG, 1'b0, "idle_after_reset");
    idle(1);

    // Full run with player 2.
    show = 1'b1; player = 3'd2;
    idle(1);
    frames(77);
    probe(300, 670, mdl(300, 670, P2), 1'b0, "reveal616_last_row");
    probe(300, 671, BG, 1'b0, "reveal616_first_hidden");
    frames(1);
    probe(300, 674, mdl(300, 674, P2), 1'b0, "reveal_saturated_bottom");
    player = 3'd1;
    frames(1);
    probe(300, 300, P2, 1'b0, "blink_phase0_start");
    frames(14);
    probe(300, 300, P2, 1'b0, "blink_phase0_end");
    frames(1);
    probe(300, 300, HI, 1'b0, "blink_phase1_start");
    frames(14);
    probe(300, 300, HI, 1'b0, "blink_phase1_end");
    frames(1);
    probe(300, 300, P2, 1'b0, "blink_phase0_again");
    frames(59);
    probe(300, 300, HI, 1'b0, "blink_before_hold");
    frames(1);
    probe(300, 300, P2, 1'b1, "hold_entry");

    // Back-to-back boundary probes also pin the one-clock latency.
    probe(183, 300, BG, 1'b1, "hold_x183");
    probe(184, 300, mdl(184, 300, P2), 1'b1, "hold_x184");
    probe(188, 300, mdl(188, 300, P2), 1'b1, "hold_x188");
    probe(673, 300, mdl(673, 300, P2), 1'b1, "hold_x673");
    probe(674, 300, BG, 1'b1, "hold_x674");
    probe(300, 675, BG, 1'b1, "hold_y675");
    probe(300, 674, mdl(300, 674, P2), 1'b1, "hold_y674");
    probe(300, 55, mdl(300, 55, P2), 1'b1, "hold_y55");
    frames(3);
    probe(300, 300, P2, 1'b1, "hold_stable");
    idle(1);
    show = 1'b0;
    idle(2);
    probe(300, 300, BG, 1'b0, "idle_after_hold");
    idle(1);

    // Abort during BLINK coincident with frame_start.
    show = 1'b1; player = 3'd0;
    idle(1);
    frames(82);
    probe(300, 300, mdl(300, 300, DRAW), 1'b0, "draw_blink_phase0");
    @(negedge clk);
    req = 1'b0; show = 1'b0; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    probe(300, 300, BG, 1'b0, "abort_priority");
    show = 1'b1; player = 3'd5;
    idle(1);
    probe(300, 55, BG, 1'b0, "restart_rows0");
    frames(1);
    probe(300, 62, mdl(300, 62, DRAW), 1'b0, "restart_rows8_last");
    probe(300, 63, BG, 1'b0, "restart_rows8_hidden");
    frames(77 + 1 + 89);
    probe(300, 300, HI, 1'b0, "invalid_before_hold");
    frames(1);
    probe(300, 300, DRAW, 1'b1, "invalid_player_hold");
    idle(1);
    show = 1'b0;
    idle(2);

    // Draw result all the way to HOLD.
    show = 1'b1; player = 3'd0;
    idle(1);
    frames(79 + 90);
    probe(300, 300, DRAW, 1'b1, "draw_player_hold");
    idle(3);

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
